// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared state encoding, timer width and alignment helper
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mau_state_e;

  localparam int TIMER_W = 16;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_bus_timer.sv
// rtl/mem_access_unit_bus_timer.sv - bounded wait-state counter with timeout pulse
module mem_access_unit_bus_timer
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Fires during the TIMEOUT-th enabled cycle; TIMEOUT==0 disables it entirely.
  assign timeout = (TIMEOUT != 0) && en && (count_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - handshaked memory stage feeding IR/MDR and stalling the control FSM
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IR,
  input  logic              MDR,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic [DATA_W-1:0] ir_q,
  output logic [DATA_W-1:0] mdr_q,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic              mem_stall,
  output logic              mem_err
);

  mau_state_e        state_q;
  logic              bus_rd_q;
  logic              bus_wr_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] ir_data_q;
  logic [DATA_W-1:0] mdr_data_q;
  logic              ld_ir_q;
  logic              ld_mdr_q;
  logic              mem_err_q;
  logic              timeout;
  logic              req;
  logic [ADDR_W-1:0] req_addr;

  assign req      = MemRead | MemWrite;
  assign req_addr = IorD ? alu_out : pc;

  mem_access_unit_bus_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_bus_timer (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (state_q != S_BUSY),
    .en     (state_q == S_BUSY),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      ir_data_q   <= '0;
      mdr_data_q  <= '0;
      ld_ir_q     <= 1'b0;
      ld_mdr_q    <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if ((MemRead & MemWrite) || !word_aligned(req_addr[1:0])) begin
              mem_err_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              bus_rd_q    <= MemRead;
              bus_wr_q    <= MemWrite;
              bus_addr_q  <= req_addr;
              bus_wdata_q <= wdata;
              ld_ir_q     <= IR & MemRead;
              ld_mdr_q    <= MDR & MemRead;
              state_q     <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (bus_ready) begin
            if (bus_rd_q && ld_ir_q)  ir_data_q  <= bus_rdata;
            if (bus_rd_q && ld_mdr_q) mdr_data_q <= bus_rdata;
            bus_rd_q <= 1'b0;
            bus_wr_q <= 1'b0;
            state_q  <= S_DONE;
          end else if (timeout) begin
            bus_rd_q  <= 1'b0;
            bus_wr_q  <= 1'b0;
            mem_err_q <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_rd    = bus_rd_q;
  assign bus_wr    = bus_wr_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign ir_q      = ir_data_q;
  assign mdr_q     = mdr_data_q;
  assign mem_err   = mem_err_q;
  assign op        = ir_data_q[31:26];
  assign func      = ir_data_q[5:0];

  assign mem_stall = ((state_q == S_IDLE) & req) |
                     ((state_q == S_BUSY) & ~bus_ready & ~timeout);

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized transaction bench against a transaction-level model
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        nrst;
  logic        MemRead, MemWrite, IorD, IR, MDR;
  logic [31:0] pc, alu_out, wdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_rd, bus_wr, bus_ready;
  logic [31:0] ir_q, mdr_q;
  logic [5:0]  op, func;
  logic        mem_stall, mem_err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] ir_m, mdr_m;
  logic        err_m;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IorD     (IorD),
    .IR       (IR),
    .MDR      (MDR),
    .pc       (pc),
    .alu_out  (alu_out),
    .wdata    (wdata),
    .bus_addr (bus_addr),
    .bus_rd   (bus_rd),
    .bus_wr   (bus_wr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready),
    .ir_q     (ir_q),
    .mdr_q    (mdr_q),
    .op       (op),
    .func     (func),
    .mem_stall(mem_stall),
    .mem_err  (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drop_requests();
    MemRead = 0; MemWrite = 0; IorD = 0; IR = 0; MDR = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "/ir_q"}, ir_q, ir_m);
    chk({tag, "/mdr_q"}, mdr_q, mdr_m);
    chk({tag, "/op"}, {26'd0, op}, {26'd0, ir_m[31:26]});
    chk({tag, "/func"}, {26'd0, func}, {26'd0, ir_m[5:0]});
    chk({tag, "/mem_err"}, {31'd0, mem_err}, {31'd0, err_m});
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 0;
    drop_requests();
    bus_ready = 0;
    ir_m = 0; mdr_m = 0; err_m = 0;
    #1;
    chk("rst/bus_rd", {31'd0, bus_rd}, 32'd0);
    chk("rst/bus_wr", {31'd0, bus_wr}, 32'd0);
    chk("rst/bus_addr", bus_addr, 32'd0);
    chk("rst/bus_wdata", bus_wdata, 32'd0);
    chk("rst/stall", {31'd0, mem_stall}, 32'd0);
    check_regs("rst");
    @(negedge clk);
    nrst = 1;
  endtask

  // One control-FSM request: held until stall releases, memory answers after w wait states.
  task automatic do_txn(input string tag, input logic rd, input logic wr, input logic iord,
                        input logic ld_ir, input logic ld_mdr, input logic [31:0] pcv,
                        input logic [31:0] aluv, input logic [31:0] wd,
                        input logic [31:0] rdv, input int w);
    logic [31:0] addr;
    bit bad, tout;
    int nbusy;
    addr  = iord ? aluv : pcv;
    bad   = (rd && wr) || (addr[1:0] != 2'b00);
    tout  = (TIMEOUT != 0) && (w >= TIMEOUT);
    nbusy = tout ? TIMEOUT : w + 1;

    @(negedge clk);
    MemRead = rd; MemWrite = wr; IorD = iord; IR = ld_ir; MDR = ld_mdr;
    pc = pcv; alu_out = aluv; wdata = wd; bus_ready = 0;
    #1 chk({tag, "/stall_req"}, {31'd0, mem_stall}, {31'd0, rd | wr});
    @(posedge clk);

    if ((rd || wr) && !bad) begin
      for (int k = 0; k < nbusy; k++) begin
        @(negedge clk);
        bus_ready = (k == w);
        bus_rdata = (k == w) ? rdv : $urandom;
        #1;
        chk({tag, "/bus_rd"}, {31'd0, bus_rd}, {31'd0, rd});
        chk({tag, "/bus_wr"}, {31'd0, bus_wr}, {31'd0, wr});
        chk({tag, "/bus_addr"}, bus_addr, addr);
        if (wr) chk({tag, "/bus_wdata"}, bus_wdata, wd);
        chk({tag, "/stall_busy"}, {31'd0, mem_stall},
            {31'd0, (k != w) && !(TIMEOUT != 0 && k == TIMEOUT - 1)});
        @(posedge clk);
      end
    end

    // Request still held here: the completion cycle must ignore it.
    @(negedge clk);
    bus_ready = 0;
    #1;
    chk({tag, "/done_rd"}, {31'd0, bus_rd}, 32'd0);
    chk({tag, "/done_wr"}, {31'd0, bus_wr}, 32'd0);
    chk({tag, "/done_stall"}, {31'd0, mem_stall}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    drop_requests();

    if (rd || wr) begin
      if (bad || tout) err_m = 1;
      else if (rd) begin
        if (ld_ir)  ir_m  = rdv;
        if (ld_mdr) mdr_m = rdv;
      end
    end
    #1 check_regs(tag);
  endtask

  initial begin
    nrst = 0;
    drop_requests();
    pc = 0; alu_out = 0; wdata = 0; bus_rdata = 0; bus_ready = 0;
    ir_m = 0; mdr_m = 0; err_m = 0;
    #1;
    chk("init/bus_rd", {31'd0, bus_rd}, 32'd0);
    check_regs("init");
    do_reset();

    do_txn("ir_read", 1, 0, 0, 1, 0, 32'h4, 32'h0, 32'h0, 32'h2008_0005, 0);
    chk("ir_read/op08", {26'd0, op}, 32'h08);
    do_txn("mdr_read", 1, 0, 1, 0, 1, 32'h8, 32'h10, 32'h0, 32'hCAFE_0123, 3);
    do_txn("write", 0, 1, 1, 1, 1, 32'h8, 32'h20, 32'hDEAD_BEEF, 32'h1111_2222, 2);
    do_txn("misalign", 1, 0, 1, 1, 0, 32'h8, 32'h13, 32'h0, 32'h3333_4444, 0);
    do_txn("illegal", 1, 1, 0, 1, 1, 32'h40, 32'h0, 32'h5, 32'h5555_6666, 0);

    // Reset while the access is in flight, with mem_err already set.
    @(negedge clk);
    MemRead = 1; IR = 1; IorD = 0; pc = 32'h100;
    @(posedge clk);
    @(negedge clk);
    drop_requests();
    #1 chk("midrst/bus_rd_before", {31'd0, bus_rd}, 32'd1);
    #2 nrst = 0;
    ir_m = 0; mdr_m = 0; err_m = 0;
    #1;
    chk("midrst/bus_rd", {31'd0, bus_rd}, 32'd0);
    chk("midrst/stall", {31'd0, mem_stall}, 32'd0);
    check_regs("midrst");
    @(negedge clk);
    nrst = 1;

    do_txn("ir_seed", 1, 0, 0, 1, 0, 32'h200, 32'h0, 32'h0, 32'h8C22_0044, 1);
    do_txn("timeout", 1, 0, 0, 1, 1, 32'h300, 32'h0, 32'h0, 32'hFFFF_FFFF, 40);
    do_txn("w15_edge", 1, 0, 0, 0, 1, 32'h304, 32'h0, 32'h0, 32'h0BAD_F00D, 15);
    do_reset();

    for (int t = 0; t < 150; t++) begin
      int kind, w;
      logic rd, wr, iord, lir, lmdr;
      logic [31:0] pcv, aluv;
      kind = $urandom_range(0, 11);
      w    = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
      iord = $urandom_range(0, 1);
      pcv  = $urandom & 32'hFFFF_FFFC;
      aluv = $urandom & 32'hFFFF_FFFC;
      rd = 1; wr = 0; lir = $urandom_range(0, 1); lmdr = $urandom_range(0, 1);
      case (kind)
        0, 1, 2: lir = 1;
        3, 4:    lmdr = 1;
        5:       begin lir = 1; lmdr = 1; end
        6, 7:    begin rd = 0; wr = 1; end
        8:       begin if (iord) aluv[1:0] = 2'($urandom_range(1, 3));
                       else pcv[1:0] = 2'($urandom_range(1, 3)); end
        9:       wr = 1;
        10:      rd = 0;
        default: ;
      endcase
      do_txn("rand", rd, wr, iord, lir, lmdr, pcv, aluv, $urandom, $urandom, w);
      if (err_m && $urandom_range(0, 1) == 1) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
